// File: rtl/hc8_pkg.sv
// Shared constants, state encoding and opcode-class decode for the HC8 write-back path.
package hc8_pkg;

    localparam int DATA_W = 8;

    localparam logic [3:0] OP_SC  = 4'b0000;
    localparam logic [3:0] OP_LD  = 4'b1000;
    localparam logic [3:0] OP_ST  = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_LSI = 4'b1100;

    typedef enum logic [1:0] {IDLE, EXEC, RAM, DONE} state_t;

    typedef enum logic [1:0] {CLS_NONE, CLS_PUSH, CLS_REPL, CLS_STORE} wb_class_t;

    function automatic wb_class_t decode_class(input logic [3:0] op);
        wb_class_t cls;
        // NOTE: default first so every path assigns cls; in always_comb this is what prevents a latch.
        cls = CLS_NONE;
        if (op == OP_SC || op == OP_LD || op == OP_LSI)
            cls = CLS_PUSH;
        else if ((op >= 4'h1 && op <= 4'h7) || op == OP_LDI)
            cls = CLS_REPL;
        else if (op == OP_ST)
            cls = CLS_STORE;
        return cls;
    endfunction

endpackage

// File: rtl/hc8_stack3.sv
// Three-level register stack (A top, C bottom) with push, replace and synchronous clear.
module hc8_stack3
    import hc8_pkg::*;
(
    input  logic              clk,
    input  logic              clr_n,
    input  logic              push,
    input  logic              replace,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] level_a,
    output logic [DATA_W-1:0] level_b,
    output logic [DATA_W-1:0] level_c
);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            level_a <= '0;
            level_b <= '0;
            level_c <= '0;
        end else if (push) begin
            // NOTE: non-blocking so B and C take the pre-edge A and B, not the freshly written ones.
            level_a <= din;
            level_b <= level_a;
            level_c <= level_b;
        end else if (replace) begin
            level_a <= din;
        end
    end

endmodule

// File: rtl/hc8_bus_wb.sv
// Write-back sink: commits one instruction's bus value to the stack or RAM under a valid/ready handshake.
module hc8_bus_wb
    import hc8_pkg::*;
#(
    parameter int RAM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [7:0]        instruction,
    input  logic [DATA_W-1:0] data_bus,
    output logic [DATA_W-1:0] level_A,
    output logic [DATA_W-1:0] level_B,
    output logic [DATA_W-1:0] level_C,
    output logic              ram_we,
    output logic [3:0]        ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic              ram_ack,
    output logic              wb_done,
    output logic              wb_err
);

    localparam logic [7:0] TIMEOUT_Q = 8'(RAM_TIMEOUT);

    state_t            state;
    logic [7:0]        instr_q;
    logic [DATA_W-1:0] bus_q;
    logic [7:0]        wait_cnt;
    wb_class_t         cls;

    assign cls         = decode_class(instr_q[7:4]);
    assign instr_ready = (state == IDLE);
    assign ram_we      = (state == RAM);
    assign wb_done     = (state == DONE);

    hc8_stack3 u_stack (
        .clk     (clk),
        .clr_n   (rst_n),
        .push    (state == EXEC && cls == CLS_PUSH),
        .replace (state == EXEC && cls == CLS_REPL),
        .din     (bus_q),
        .level_a (level_A),
        .level_b (level_B),
        .level_c (level_C)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            instr_q   <= '0;
            bus_q     <= '0;
            wait_cnt  <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            wb_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instruction;
                        bus_q   <= data_bus;
                        wb_err  <= 1'b0;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (cls == CLS_STORE) begin
                        ram_addr  <= instr_q[3:0];
                        ram_wdata <= level_A;
                        wait_cnt  <= '0;
                        state     <= RAM;
                    end else begin
                        state <= DONE;
                    end
                end
                RAM: begin
                    // An ack on the expiry edge still counts as success.
                    if (ram_ack) begin
                        state <= DONE;
                    end else if (wait_cnt + 8'd1 == TIMEOUT_Q) begin
                        wb_err <= 1'b1;
                        state  <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
